// File: rtl/data_cal_seq.sv
// Sequencer for the nibble-sum calculator: loads one word with sel=0, steps sel 1..3,
// captures the three sums as they emerge and offers them as one packed result.
module data_cal_seq #(
    parameter int CAL_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    output logic [15:0] cal_d,
    output logic [1:0]  cal_sel,
    input  logic [4:0]  cal_out,
    input  logic        cal_validout,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [14:0] res_data,
    output logic        res_err
);

    typedef enum logic [2:0] {
        IDLE,
        ISS1,
        ISS2,
        ISS3,
        DRAIN,
        RESP
    } state_t;

    state_t      state;
    logic [15:0] hold;
    logic [4:0]  sum1;
    logic [4:0]  sum2;
    logic [4:0]  sum3;
    logic        err;
    logic [1:0]  tag_pipe [CAL_LAT];
    logic [1:0]  tag_out;

    // Tag 0 marks an empty slot; tags 1..3 name the sum arriving on cal_out.
    assign tag_out = tag_pipe[CAL_LAT-1];

    // The pass-through paths are held low for as long as rst is asserted.
    assign in_ready = !rst && (state == IDLE);
    assign cal_d    = rst ? 16'h0000 : ((state == IDLE) ? in_data : hold);
    assign res_data = {sum3, sum2, sum1};
    assign res_err  = err;

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            hold      <= '0;
            cal_sel   <= '0;
            res_valid <= 1'b0;
            sum1      <= '0;
            sum2      <= '0;
            sum3      <= '0;
            err       <= 1'b0;
            // NOTE: the tag pipe is a shift register, not a RAM, so it is reset
            // with the rest of the state; a stale tag would cause a bogus capture.
            for (int i = 0; i < CAL_LAT; i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            tag_pipe[0] <= cal_sel;
            for (int i = 1; i < CAL_LAT; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end

            if (tag_out != 2'd0) begin
                case (tag_out)
                    2'd1:    sum1 <= cal_out;
                    2'd2:    sum2 <= cal_out;
                    default: sum3 <= cal_out;
                endcase
                if (!cal_validout) begin
                    err <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        hold    <= in_data;
                        cal_sel <= 2'd1;
                        state   <= ISS1;
                    end
                end
                ISS1: begin
                    cal_sel <= 2'd2;
                    state   <= ISS2;
                end
                ISS2: begin
                    cal_sel <= 2'd3;
                    state   <= ISS3;
                end
                ISS3: begin
                    cal_sel <= 2'd0;
                    state   <= DRAIN;
                end
                DRAIN: begin
                    // sum3 is captured on this same edge, so the result is complete in RESP.
                    if (tag_out == 2'd3) begin
                        res_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        err       <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    cal_sel   <= 2'd0;
                    res_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_cal_seq.sv
// Directed bench for data_cal_seq: two instances (CAL_LAT=1 and 3), each driving a
// behavioural nibble-sum calculator; expected results are hand-computed constants.
module tb_data_cal_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid1;
    logic        in_valid3;
    logic        res_ready;
    logic        force_err;
    logic [15:0] in_data;

    logic        in_ready1, res_valid1, res_err1, cal_validout1;
    logic [15:0] cal_d1;
    logic [1:0]  cal_sel1;
    logic [4:0]  cal_out1;
    logic [14:0] res_data1;

    logic        in_ready3, res_valid3, res_err3, cal_validout3;
    logic [15:0] cal_d3;
    logic [1:0]  cal_sel3;
    logic [4:0]  cal_out3;
    logic [14:0] res_data3;

    int n_vec  = 0;
    int n_miss = 0;

    data_cal_seq #(.CAL_LAT(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data),
        .cal_d(cal_d1), .cal_sel(cal_sel1), .cal_out(cal_out1), .cal_validout(cal_validout1),
        .res_valid(res_valid1), .res_ready(res_ready), .res_data(res_data1), .res_err(res_err1)
    );

    data_cal_seq #(.CAL_LAT(3)) dut3 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data),
        .cal_d(cal_d3), .cal_sel(cal_sel3), .cal_out(cal_out3), .cal_validout(cal_validout3),
        .res_valid(res_valid3), .res_ready(res_ready), .res_data(res_data3), .res_err(res_err3)
    );

    // Calculator: sel=0 loads the word; sel=k returns nibble k plus nibble 0.
    function automatic logic [4:0] nib_sum(input logic [15:0] w, input logic [1:0] sel);
        case (sel)
            2'd1:    return {1'b0, w[7:4]}   + {1'b0, w[3:0]};
            2'd2:    return {1'b0, w[11:8]}  + {1'b0, w[3:0]};
            2'd3:    return {1'b0, w[15:12]} + {1'b0, w[3:0]};
            default: return 5'd0;
        endcase
    endfunction

    logic [15:0] mw1;
    always @(posedge clk) begin
        if (cal_sel1 == 2'd0) mw1 <= cal_d1;
        cal_out1      <= nib_sum(mw1, cal_sel1);
        cal_validout1 <= (cal_sel1 != 2'd0) && !(force_err && cal_sel1 == 2'd2);
    end

    logic [15:0] mw3;
    logic [4:0]  mo3 [3];
    logic        mv3 [3];
    always @(posedge clk) begin
        if (cal_sel3 == 2'd0) mw3 <= cal_d3;
        mo3[0] <= nib_sum(mw3, cal_sel3);
        mv3[0] <= (cal_sel3 != 2'd0);
        mo3[1] <= mo3[0];
        mv3[1] <= mv3[0];
        mo3[2] <= mo3[1];
        mv3[2] <= mv3[1];
    end
    assign cal_out3      = mo3[2];
    assign cal_validout3 = mv3[2];

    task automatic test_reset();
        rst = 1'b1; in_valid1 = 1'b0; in_valid3 = 1'b0; res_ready = 1'b0; force_err = 1'b0;
        in_data = 16'hABCD;
        repeat (2) @(negedge clk);
        n_vec++; if (in_ready1 !== 1'b0) begin n_miss++; $display("FAIL rst_in_ready: got %b want 0", in_ready1); end
        n_vec++; if (cal_d1 !== 16'h0000) begin n_miss++; $display("FAIL rst_cal_d: got %h want 0000", cal_d1); end
        n_vec++; if (cal_sel1 !== 2'd0) begin n_miss++; $display("FAIL rst_cal_sel: got %0d want 0", cal_sel1); end
        n_vec++; if (res_valid1 !== 1'b0) begin n_miss++; $display("FAIL rst_res_valid: got %b want 0", res_valid1); end
        n_vec++; if (res_data1 !== 15'h0000) begin n_miss++; $display("FAIL rst_res_data: got %h want 0000", res_data1); end
        n_vec++; if (res_err1 !== 1'b0) begin n_miss++; $display("FAIL rst_res_err: got %b want 0", res_err1); end
        rst = 1'b0;
        #1;
        n_vec++; if (in_ready1 !== 1'b1) begin n_miss++; $display("FAIL rel_in_ready: got %b want 1", in_ready1); end
        n_vec++; if (in_ready3 !== 1'b1) begin n_miss++; $display("FAIL rel_in_ready3: got %b want 1", in_ready3); end
        n_vec++; if (cal_d1 !== 16'hABCD) begin n_miss++; $display("FAIL idle_pass_cal_d: got %h want abcd", cal_d1); end
    endtask

    task automatic test_basic();
        logic [1:0] exp_sel;
        @(negedge clk);
        res_ready = 1'b0; in_data = 16'h1234; in_valid1 = 1'b1;
        #1;
        n_vec++; if (in_ready1 !== 1'b1) begin n_miss++; $display("FAIL basic_c0_in_ready: got %b want 1", in_ready1); end
        n_vec++; if (cal_sel1 !== 2'd0) begin n_miss++; $display("FAIL basic_c0_sel: got %0d want 0", cal_sel1); end
        n_vec++; if (cal_d1 !== 16'h1234) begin n_miss++; $display("FAIL basic_c0_cal_d: got %h want 1234", cal_d1); end
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            in_valid1 = 1'b0; in_data = 16'h5555;
            #1;
            exp_sel = (c <= 3) ? 2'(c) : 2'd0;
            n_vec++; if (cal_sel1 !== exp_sel) begin n_miss++; $display("FAIL basic_sel c%0d: got %0d want %0d", c, cal_sel1, exp_sel); end
            n_vec++; if (cal_d1 !== 16'h1234) begin n_miss++; $display("FAIL basic_cal_d c%0d: got %h want 1234", c, cal_d1); end
            n_vec++; if (in_ready1 !== 1'b0) begin n_miss++; $display("FAIL basic_in_ready c%0d: got %b want 0", c, in_ready1); end
            n_vec++; if (res_valid1 !== 1'b0) begin n_miss++; $display("FAIL basic_res_valid c%0d: got %b want 0", c, res_valid1); end
        end
        @(negedge clk); #1;
        n_vec++; if (res_valid1 !== 1'b1) begin n_miss++; $display("FAIL basic_c5_valid: got %b want 1", res_valid1); end
        n_vec++; if (res_data1 !== 15'h14C7) begin n_miss++; $display("FAIL basic_c5_data: got %h want 14c7", res_data1); end
        n_vec++; if (res_err1 !== 1'b0) begin n_miss++; $display("FAIL basic_c5_err: got %b want 0", res_err1); end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        #1;
        n_vec++; if (res_valid1 !== 1'b0) begin n_miss++; $display("FAIL basic_c6_valid: got %b want 0", res_valid1); end
        n_vec++; if (in_ready1 !== 1'b1) begin n_miss++; $display("FAIL basic_c6_in_ready: got %b want 1", in_ready1); end
    endtask

    task automatic test_ffff();
        @(negedge clk);
        res_ready = 1'b1; in_data = 16'hFFFF; in_valid1 = 1'b1;
        repeat (4) begin
            @(negedge clk);
            in_valid1 = 1'b0;
        end
        #1;
        n_vec++; if (res_valid1 !== 1'b0) begin n_miss++; $display("FAIL ffff_c4_valid: got %b want 0", res_valid1); end
        @(negedge clk); #1;
        n_vec++; if (res_valid1 !== 1'b1) begin n_miss++; $display("FAIL ffff_c5_valid: got %b want 1", res_valid1); end
        n_vec++; if (res_data1 !== 15'h7BDE) begin n_miss++; $display("FAIL ffff_c5_data: got %h want 7bde", res_data1); end
        n_vec++; if (res_err1 !== 1'b0) begin n_miss++; $display("FAIL ffff_c5_err: got %b want 0", res_err1); end
        @(negedge clk); #1;
        n_vec++; if (res_valid1 !== 1'b0) begin n_miss++; $display("FAIL ffff_c6_valid: got %b want 0", res_valid1); end
        n_vec++; if (in_ready1 !== 1'b1) begin n_miss++; $display("FAIL ffff_c6_in_ready: got %b want 1", in_ready1); end
        res_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        res_ready = 1'b0; in_data = 16'hA5C3; in_valid1 = 1'b1;
        @(negedge clk);
        in_valid1 = 1'b0;
        repeat (4) @(negedge clk);
        // cycle 5: a competing word is offered while the result is held
        in_data = 16'hBEEF; in_valid1 = 1'b1;
        for (int c = 5; c <= 14; c++) begin
            if (c > 5) @(negedge clk);
            #1;
            n_vec++; if (res_valid1 !== 1'b1) begin n_miss++; $display("FAIL bp_valid c%0d: got %b want 1", c, res_valid1); end
            n_vec++; if (res_data1 !== 15'h350F) begin n_miss++; $display("FAIL bp_data c%0d: got %h want 350f", c, res_data1); end
            n_vec++; if (res_err1 !== 1'b0) begin n_miss++; $display("FAIL bp_err c%0d: got %b want 0", c, res_err1); end
            n_vec++; if (in_ready1 !== 1'b0) begin n_miss++; $display("FAIL bp_in_ready c%0d: got %b want 0", c, in_ready1); end
            n_vec++; if (cal_sel1 !== 2'd0) begin n_miss++; $display("FAIL bp_sel c%0d: got %0d want 0", c, cal_sel1); end
        end
        @(negedge clk);
        res_ready = 1'b1;
        #1;
        n_vec++; if (in_ready1 !== 1'b0) begin n_miss++; $display("FAIL bp_hs_in_ready: got %b want 0", in_ready1); end
        @(negedge clk);
        res_ready = 1'b0; in_valid1 = 1'b0;
        #1;
        n_vec++; if (res_valid1 !== 1'b0) begin n_miss++; $display("FAIL bp_after_valid: got %b want 0", res_valid1); end
        n_vec++; if (in_ready1 !== 1'b1) begin n_miss++; $display("FAIL bp_after_in_ready: got %b want 1", in_ready1); end
        n_vec++; if (cal_sel1 !== 2'd0) begin n_miss++; $display("FAIL bp_after_sel: got %0d want 0", cal_sel1); end
    endtask

    task automatic test_error();
        @(negedge clk);
        force_err = 1'b1; res_ready = 1'b0; in_data = 16'h0000; in_valid1 = 1'b1;
        @(negedge clk);
        in_valid1 = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        n_vec++; if (res_valid1 !== 1'b1) begin n_miss++; $display("FAIL err_valid: got %b want 1", res_valid1); end
        n_vec++; if (res_err1 !== 1'b1) begin n_miss++; $display("FAIL err_flag: got %b want 1", res_err1); end
        n_vec++; if (res_data1 !== 15'h0000) begin n_miss++; $display("FAIL err_data: got %h want 0000", res_data1); end
        res_ready = 1'b1; force_err = 1'b0;
        @(negedge clk);
        res_ready = 1'b0;
        #1;
        n_vec++; if (res_err1 !== 1'b0) begin n_miss++; $display("FAIL err_clear: got %b want 0", res_err1); end
        @(negedge clk);
        in_data = 16'h1111; in_valid1 = 1'b1;
        @(negedge clk);
        in_valid1 = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        n_vec++; if (res_valid1 !== 1'b1) begin n_miss++; $display("FAIL err_next_valid: got %b want 1", res_valid1); end
        n_vec++; if (res_err1 !== 1'b0) begin n_miss++; $display("FAIL err_next_flag: got %b want 0", res_err1); end
        n_vec++; if (res_data1 !== 15'h0842) begin n_miss++; $display("FAIL err_next_data: got %h want 0842", res_data1); end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        res_ready = 1'b0; in_data = 16'h1234; in_valid1 = 1'b1;
        @(negedge clk);
        in_valid1 = 1'b0;
        @(negedge clk); #1;
        n_vec++; if (cal_sel1 !== 2'd2) begin n_miss++; $display("FAIL mid_iss2_sel: got %0d want 2", cal_sel1); end
        rst = 1'b1;
        #1;
        n_vec++; if (in_ready1 !== 1'b0) begin n_miss++; $display("FAIL mid_rst_in_ready: got %b want 0", in_ready1); end
        n_vec++; if (cal_d1 !== 16'h0000) begin n_miss++; $display("FAIL mid_rst_cal_d: got %h want 0000", cal_d1); end
        n_vec++; if (cal_sel1 !== 2'd0) begin n_miss++; $display("FAIL mid_rst_sel: got %0d want 0", cal_sel1); end
        n_vec++; if (res_valid1 !== 1'b0) begin n_miss++; $display("FAIL mid_rst_valid: got %b want 0", res_valid1); end
        n_vec++; if (res_data1 !== 15'h0000) begin n_miss++; $display("FAIL mid_rst_data: got %h want 0000", res_data1); end
        n_vec++; if (res_err1 !== 1'b0) begin n_miss++; $display("FAIL mid_rst_err: got %b want 0", res_err1); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_vec++; if (in_ready1 !== 1'b1) begin n_miss++; $display("FAIL mid_rel_in_ready: got %b want 1", in_ready1); end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk); #1;
            n_vec++; if (res_valid1 !== 1'b0) begin n_miss++; $display("FAIL mid_idle_valid c%0d: got %b want 0", c, res_valid1); end
            n_vec++; if (cal_sel1 !== 2'd0) begin n_miss++; $display("FAIL mid_idle_sel c%0d: got %0d want 0", c, cal_sel1); end
        end
        @(negedge clk);
        in_data = 16'h0F0F; in_valid1 = 1'b1;
        @(negedge clk);
        in_valid1 = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_vec++; if (res_valid1 !== 1'b0) begin n_miss++; $display("FAIL mid_new_c4_valid: got %b want 0", res_valid1); end
        @(negedge clk); #1;
        n_vec++; if (res_valid1 !== 1'b1) begin n_miss++; $display("FAIL mid_new_valid: got %b want 1", res_valid1); end
        n_vec++; if (res_data1 !== 15'h3FCF) begin n_miss++; $display("FAIL mid_new_data: got %h want 3fcf", res_data1); end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_lat3();
        logic [1:0] exp_sel;
        @(negedge clk);
        res_ready = 1'b0; in_data = 16'h1234; in_valid3 = 1'b1;
        #1;
        n_vec++; if (in_ready3 !== 1'b1) begin n_miss++; $display("FAIL lat3_c0_in_ready: got %b want 1", in_ready3); end
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            in_valid3 = 1'b0;
            #1;
            exp_sel = (c <= 3) ? 2'(c) : 2'd0;
            n_vec++; if (cal_sel3 !== exp_sel) begin n_miss++; $display("FAIL lat3_sel c%0d: got %0d want %0d", c, cal_sel3, exp_sel); end
            n_vec++; if (res_valid3 !== 1'b0) begin n_miss++; $display("FAIL lat3_valid c%0d: got %b want 0", c, res_valid3); end
        end
        @(negedge clk); #1;
        n_vec++; if (res_valid3 !== 1'b1) begin n_miss++; $display("FAIL lat3_c7_valid: got %b want 1", res_valid3); end
        n_vec++; if (res_data3 !== 15'h14C7) begin n_miss++; $display("FAIL lat3_c7_data: got %h want 14c7", res_data3); end
        n_vec++; if (res_err3 !== 1'b0) begin n_miss++; $display("FAIL lat3_c7_err: got %b want 0", res_err3); end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        #1;
        n_vec++; if (res_valid3 !== 1'b0) begin n_miss++; $display("FAIL lat3_c8_valid: got %b want 0", res_valid3); end
        n_vec++; if (in_ready3 !== 1'b1) begin n_miss++; $display("FAIL lat3_c8_in_ready: got %b want 1", in_ready3); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ffff();
        test_backpressure();
        test_error();
        test_reset_mid();
        test_lat3();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/data_cal_seq.md
Name: data_cal_seq

Overview:
- Sequencer that drives the d/sel input side of the nibble-sum calculator (`data_cal`) and collects its out/validout results.
- Accepts one 16-bit word on a valid/ready input and loads it into the calculator with sel=0.
- Steps the calculator through sel=1, 2 and 3, then captures the three 5-bit sums.
- Presents the three sums as one packed result on a valid/ready output. Sits between a word producer and result consumers.

Parameters:
- CAL_LAT, 1, cycles from driving cal_sel until the matching cal_out/cal_validout is visible. Legal range 1..4.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input word valid.
- in_ready  output  1  sequencer can accept a word.
- in_data  input  16  word to process.
- cal_d  output  16  data bus to the calculator.
- cal_sel  output  2  mode select to the calculator.
- cal_out  input  5  calculator sum.
- cal_validout  input  1  calculator sum valid.
- res_valid  output  1  result valid.
- res_ready  input  1  consumer accepts result.
- res_data  output  15  packed result: {sum3[14:10], sum2[9:5], sum1[4:0]}.
- res_err  output  1  qualified by res_valid; 1 if any expected capture saw cal_validout=0.

Behaviour:
- Reset (async assert) sets:
  - state IDLE.
  - Outputs: in_ready=0 during reset, 1 in the first cycle after release; cal_d=0, cal_sel=0, res_valid=0, res_data=0, res_err=0.
  - Tag pipeline cleared.
- Reset mid-operation abandons the word and any held result. No partial result is ever presented.
- State machine: IDLE -> ISS1 -> ISS2 -> ISS3 -> DRAIN -> RESP -> IDLE.
- IDLE:
  - Outputs: in_ready=1, cal_sel=0, cal_d=in_data (combinational pass of in_data while in IDLE).
  - On in_valid&in_ready (cycle T): register in_data into a hold register and go to ISS1. The calculator loads the word at the end of T.
- ISS1/ISS2/ISS3: one cycle each (T+1, T+2, T+3).
  - Outputs: cal_sel = 1/2/3, cal_d = hold register, in_ready=0.
  - Each issue pushes tag k (1..3) into a CAL_LAT-deep tag shift pipeline.
- Capture: when tag k exits the pipeline (cycle T+k+CAL_LAT):
  - sum_k <= cal_out.
  - If cal_validout=0, set sticky err bit.
  - Capture occurs in any state, including ISS2/ISS3/DRAIN.
- DRAIN:
  - Outputs: cal_sel=0, cal_d = hold register.
  - Waits until the pipeline is empty, i.e. sum3 captured at T+3+CAL_LAT, then goes to RESP.
- RESP:
  - res_valid=1 from cycle T+4+CAL_LAT; res_data and res_err are stable while res_valid=1 and res_ready=0.
  - cal_sel=0, in_ready=0.
  - On res_ready: return to IDLE and clear the err bit.
  - No new word is accepted in the handshake cycle.
- Widths: sums are 5-bit values from the calculator (max 30), captured unmodified. No arithmetic is done inside this block.
- Throughput: one word per 5+CAL_LAT cycles minimum (accept cycle through result handshake, then IDLE).
- in_valid while not in IDLE: ignored, since in_ready=0. The producer must hold the word per valid/ready rules.
- res_ready asserted while res_valid=0: ignored.

Test Plan:
- CAL_LAT=1 with a calculator model; accept in_data=16'h1234 at cycle 0 -> cal_sel 0,1,2,3 at cycles 0..3; res_valid first high at cycle 5; res_data=15'h14C7 (sums 7,6,5); res_err=0.
- in_data=16'hFFFF, res_ready held 1 -> res_data=15'h7BDE (30,30,30); single-cycle res_valid; in_ready=1 again the cycle after.
- Backpressure: res_ready=0 for 10 cycles after res_valid rises -> res_data/res_err stable; in_ready=0; cal_sel=0 throughout; one handshake on res_ready=1.
- Error: model forces cal_validout=0 on the sum2 capture cycle, in_data=16'h0000 -> res_err=1, res_data=0; next word 16'h1111 -> res_err=0, res_data={2,2,2}=15'h0842.
- Reset: assert rst during ISS2 -> all outputs 0 immediately; after release, IDLE with in_ready=1; no res_valid until a new word completes.
- CAL_LAT=3 with a delayed model, in_data=16'h1234 -> res_valid first high at cycle 7; res_data=15'h14C7.
